// File: rtl/seq_bit_serializer_pkg.sv
//==============================================================================
// Module  : seq_bit_serializer_pkg
// Brief   : Shared FSM state encoding and default pattern geometry for the
//           bit serializer and the sequence detector it feeds.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_bit_serializer_pkg;

   // Pattern width shared with the downstream sequence detector.
   localparam int c_DEFAULT_PATTERN_W = 8;
   // Default number of buffered pattern words.
   localparam int c_DEFAULT_DEPTH     = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_byte_fifo.sv
//==============================================================================
// Module  : seq_byte_fifo
// Brief   : Synchronous FIFO, DATA_W x DEPTH, with occupancy level. A push
//           while full is dropped even if a pop happens in the same cycle.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_byte_fifo
   import seq_bit_serializer_pkg::*;
#(
   parameter int DATA_W = c_DEFAULT_PATTERN_W,
   parameter int DEPTH  = c_DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_data,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign o_full    = (r_level == c_LVL_W'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Storage array: contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_push_ok && !w_pop_ok) begin
            r_level <= r_level + c_LVL_W'(1);
         end else if (!w_push_ok && w_pop_ok) begin
            r_level <= r_level - c_LVL_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_bit_serializer.sv
//==============================================================================
// Module  : seq_bit_serializer
// Brief   : Buffers parallel pattern words and shifts them out one bit per
//           enabled cycle, with an optional idle gap between words.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_bit_serializer
   import seq_bit_serializer_pkg::*;
#(
   parameter int DATA_W     = c_DEFAULT_PATTERN_W,
   parameter int DEPTH      = c_DEFAULT_DEPTH,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       i_load_data,
   input  logic                    i_load_valid,
   output logic                    o_load_ready,
   input  logic                    i_bit_en,
   output logic                    o_dout,
   output logic                    o_dout_valid,
   output logic                    o_word_done,
   output logic                    o_busy,
   output logic [$clog2(DEPTH):0]  o_fifo_level
);

   localparam int c_CNT_W = $clog2(DATA_W);
   localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_INIT =
      (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;

   ser_state_t          r_state,      w_state_nxt;
   logic [DATA_W-1:0]   r_shift,      w_shift_nxt;
   logic [c_CNT_W-1:0]  r_bit_cnt,    w_bit_cnt_nxt;
   logic [c_GAP_W-1:0]  r_gap_cnt,    w_gap_cnt_nxt;
   logic                r_dout,       w_dout_nxt;
   logic                r_dout_valid, w_dout_valid_nxt;
   logic                r_word_done,  w_word_done_nxt;

   logic                w_load;
   logic [DATA_W-1:0]   w_fifo_data;
   logic                w_full;
   logic                w_empty;
   logic                w_first_bit;
   logic                w_next_bit;
   logic [DATA_W-1:0]   w_shifted;

   seq_byte_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (i_load_valid),
      .i_data  (i_load_data),
      .i_pop   (w_load),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );

   // Bit ordering: first bit of a fresh word and the bit following a shift.
   assign w_first_bit = (MSB_FIRST != 0) ? w_fifo_data[DATA_W-1] : w_fifo_data[0];
   assign w_next_bit  = (MSB_FIRST != 0) ? r_shift[DATA_W-2] : r_shift[1];
   assign w_shifted   = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_shift[DATA_W-1:1]};

   // Ready is held low while in reset so no word is accepted then.
   assign o_load_ready = rst_n & ~w_full;
   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_word_done  = r_word_done;
   assign o_busy       = (r_state != ST_IDLE) | ~w_empty;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_dout       <= 1'b0;
         r_dout_valid <= 1'b0;
         r_word_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_gap_cnt    <= w_gap_cnt_nxt;
         r_dout       <= w_dout_nxt;
         r_dout_valid <= w_dout_valid_nxt;
         r_word_done  <= w_word_done_nxt;
      end
   end

   // Next-state logic; every word start funnels through w_load so IDLE,
   // back-to-back and post-gap starts behave identically.
   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_gap_cnt_nxt    = r_gap_cnt;
      w_dout_nxt       = r_dout;
      w_dout_valid_nxt = r_dout_valid;
      w_word_done_nxt  = 1'b0;
      w_load           = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_load = ~w_empty;
         end
         ST_SHIFT: begin
            if (i_bit_en) begin
               if (r_bit_cnt != '0) begin
                  w_shift_nxt   = w_shifted;
                  w_dout_nxt    = w_next_bit;
                  w_bit_cnt_nxt = r_bit_cnt - c_CNT_W'(1);
               end else begin
                  w_word_done_nxt = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     w_state_nxt      = ST_GAP;
                     w_gap_cnt_nxt    = c_GAP_INIT;
                     w_dout_nxt       = 1'b0;
                     w_dout_valid_nxt = 1'b0;
                  end else if (!w_empty) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt      = ST_IDLE;
                     w_dout_nxt       = 1'b0;
                     w_dout_valid_nxt = 1'b0;
                  end
               end
            end
         end
         ST_GAP: begin
            if (i_bit_en) begin
               if (r_gap_cnt != '0) begin
                  w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
               end else if (!w_empty) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt      = ST_IDLE;
            w_dout_nxt       = 1'b0;
            w_dout_valid_nxt = 1'b0;
         end
      endcase

      if (w_load) begin
         w_state_nxt      = ST_SHIFT;
         w_shift_nxt      = w_fifo_data;
         w_dout_nxt       = w_first_bit;
         w_dout_valid_nxt = 1'b1;
         w_bit_cnt_nxt    = c_CNT_LAST;
      end
   end

endmodule

`default_nettype wire
